// File: rtl/cdc_2phase_bundled_receiver_pkg.sv
// Shared types and constants for the 2-phase bundled-data receiver.
// Holds the receiver state encoding and the base synchronizer depth.
package cdc_2phase_bundled_receiver_pkg;

  localparam int SYNC_BASE_DEPTH = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rx_state_t;

endpackage

// File: rtl/cdc_2phase_bundled_receiver_sync.sv
// Multi-flop bit synchronizer for a level or toggle crossing into the clock domain.
// Depth is the package base depth plus EXTRA_DEPTH; every stage clears to 0 on reset.
module cdc_bit_synchronizer
  import cdc_2phase_bundled_receiver_pkg::*;
#(
  parameter int EXTRA_DEPTH = 0
) (
  input  logic clock,
  input  logic clear_n,
  input  logic d,
  output logic q
);

  localparam int DEPTH = SYNC_BASE_DEPTH + EXTRA_DEPTH;

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[DEPTH-2:0], d};
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/cdc_2phase_bundled_receiver.sv
// Receiving end of a 2-phase bundled-data crossing: synchronizes the request toggle,
// captures the stable data word, presents it on valid/ready and returns an ack toggle.
module cdc_2phase_bundled_receiver
  import cdc_2phase_bundled_receiver_pkg::*;
#(
  parameter int WORD_WIDTH      = 8,
  parameter int CDC_EXTRA_DEPTH = 0
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  req_toggle_in,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic                  ack_toggle_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  protocol_error,
  output rx_state_t             state_dbg
);

  // Handshake: a word transfers on any clock edge where valid_out and ready_in
  // are both high; valid_out never drops without that transfer, and data_out
  // is frozen while valid_out is high. ready_in alone (valid_out low) does nothing.

  rx_state_t state, state_next;
  logic      req_sync;
  logic      req_last;
  logic      new_req;
  logic      capture;
  logic      accept;

  cdc_bit_synchronizer #(
    .EXTRA_DEPTH(CDC_EXTRA_DEPTH)
  ) u_req_sync (
    .clock  (clock),
    .clear_n(clear_n),
    .d      (req_toggle_in),
    .q      (req_sync)
  );

  // req_last only advances on capture, so a request seen during HOLD stays pending.
  assign new_req = (req_sync != req_last);

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (new_req) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (ready_in) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state          <= IDLE;
      req_last       <= 1'b0;
      data_out       <= '0;
      ack_toggle_out <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) begin
        data_out <= data_in;
        req_last <= req_sync;
      end
      if (accept) begin
        ack_toggle_out <= ~ack_toggle_out;
      end
      // A request arriving before the sender could have seen our ack is a violation.
      if (state == HOLD && new_req) begin
        protocol_error <= 1'b1;
      end
    end
  end

  assign valid_out = (state == HOLD);
  assign state_dbg = state;

endmodule

// File: tb/tb_cdc_2phase_bundled_receiver.sv
// Bench for cdc_2phase_bundled_receiver: two instances (extra depth 0 and 2) driven by
// a toggle sender model, with an expected-word queue and ack/error models per instance.
module tb_cdc_2phase_bundled_receiver;
  import cdc_2phase_bundled_receiver_pkg::*;

  logic       clock;
  logic       clear_n;
  logic       req   [2];
  logic [7:0] data  [2];
  logic       ready [2];
  logic       ack   [2];
  logic       valid [2];
  logic [7:0] dout  [2];
  logic       perr  [2];
  rx_state_t  st    [2];

  logic       ack_m [2];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  int checks   = 0;
  int failures = 0;

  cdc_2phase_bundled_receiver #(.WORD_WIDTH(8), .CDC_EXTRA_DEPTH(0)) dut0 (
    .clock(clock), .clear_n(clear_n), .req_toggle_in(req[0]), .data_in(data[0]),
    .ack_toggle_out(ack[0]), .valid_out(valid[0]), .ready_in(ready[0]),
    .data_out(dout[0]), .protocol_error(perr[0]), .state_dbg(st[0])
  );

  cdc_2phase_bundled_receiver #(.WORD_WIDTH(8), .CDC_EXTRA_DEPTH(2)) dut2 (
    .clock(clock), .clear_n(clear_n), .req_toggle_in(req[1]), .data_in(data[1]),
    .ack_toggle_out(ack[1]), .valid_out(valid[1]), .ready_in(ready[1]),
    .data_out(dout[1]), .protocol_error(perr[1]), .state_dbg(st[1])
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int depth_of(int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: toggle sender and consumer
  task automatic send(int d, logic [7:0] w);
    data[d] = w;
    req[d]  = ~req[d];
    if (d == 0) exp_q0.push_back(w);
    else        exp_q1.push_back(w);
  endtask

  task automatic wait_valid(int d, int exp_cycles, string tag);
    int n;
    logic [7:0] w;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!valid[d] && n < 40);
    check({tag, "_latency"}, n, exp_cycles);
    if (d == 0) w = (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'hxx;
    else        w = (exp_q1.size() > 0) ? exp_q1.pop_front() : 8'hxx;
    check({tag, "_data"}, dout[d], w);
  endtask

  task automatic consume(int d, string tag);
    ready[d] = 1'b1;
    step(1);
    ready[d] = 1'b0;
    ack_m[d] = ~ack_m[d];
    check({tag, "_ack"}, ack[d], ack_m[d]);
    check({tag, "_valid_drop"}, valid[d], 1'b0);
  endtask

  initial begin
    logic [7:0] w_a;
    logic [7:0] w_b;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; data[d] = 8'h00; ready[d] = 1'b0; ack_m[d] = 1'b0;
    end
    clear_n = 1'b0;
    step(3);
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", valid[d], 1'b0);
      check("rst_ack", ack[d], 1'b0);
      check("rst_data", dout[d], 8'h00);
      check("rst_perr", perr[d], 1'b0);
      check("rst_state", st[d], IDLE);
    end
    clear_n = 1'b1;

    // ready high while idle must not produce anything
    ready[0] = 1'b1; ready[1] = 1'b1;
    step(5);
    for (int d = 0; d < 2; d++) begin
      check("idle_ready_valid", valid[d], 1'b0);
      check("idle_ready_ack", ack[d], 1'b0);
    end
    ready[1] = 1'b0;

    // single transfer, ready already high: valid after k+2, ack after k+3
    send(0, 8'hA5);
    step(1); check("single_k_valid", valid[0], 1'b0);
    step(1); check("single_k1_valid", valid[0], 1'b0);
    step(1); check("single_k2_valid", valid[0], 1'b1);
    check("single_k2_data", dout[0], exp_q0.pop_front());
    check("single_k2_ack", ack[0], 1'b0);
    step(1);
    ack_m[0] = 1'b1;
    check("single_k3_ack", ack[0], ack_m[0]);
    check("single_k3_valid", valid[0], 1'b0);
    ready[0] = 1'b0;

    // backpressure
    send(0, 8'hA5);
    wait_valid(0, 3, "bp");
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("bp_hold_valid", valid[0], 1'b1);
      check("bp_hold_data", dout[0], 8'hA5);
      check("bp_hold_ack", ack[0], ack_m[0]);
    end
    consume(0, "bp");
    step(5);
    check("bp_ack_once", ack[0], ack_m[0]);
    check("bp_no_revalid", valid[0], 1'b0);

    // four sequential transfers on each depth
    for (int d = 0; d < 2; d++) begin
      for (int i = 1; i <= 4; i++) begin
        send(d, 8'(i));
        wait_valid(d, 3 + depth_of(d), "seq");
        consume(d, "seq");
      end
      check("seq_perr", perr[d], 1'b0);
    end

    // randomized words, backpressure and idle gaps
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 10; i++) begin
        send(d, 8'($urandom_range(0, 255)));
        wait_valid(d, 3 + depth_of(d), "rnd");
        step($urandom_range(0, 6));
        check("rnd_still_valid", valid[d], 1'b1);
        consume(d, "rnd");
        step($urandom_range(0, 3));
      end
      check("rnd_perr", perr[d], 1'b0);
    end

    // violation: second toggle while holding
    w_a = 8'($urandom_range(0, 255));
    send(0, w_a);
    wait_valid(0, 3, "viol_first");
    send(0, 8'h55);
    step(3);
    check("viol_perr", perr[0], 1'b1);
    check("viol_data_frozen", dout[0], w_a);
    check("viol_valid", valid[0], 1'b1);
    consume(0, "viol_first");
    wait_valid(0, 1, "viol_second");
    check("viol_perr_sticky", perr[0], 1'b1);
    consume(0, "viol_second");
    step(5);
    check("viol_perr_sticky2", perr[0], 1'b1);
    check("viol_no_extra", valid[0], 1'b0);

    // reset mid-HOLD (sender reset together with the receiver)
    send(0, 8'h3C);
    wait_valid(0, 3, "rst_hold");
    clear_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; ack_m[d] = 1'b0;
    end
    step(1);
    clear_n = 1'b1;
    check("midrst_valid", valid[0], 1'b0);
    check("midrst_ack", ack[0], 1'b0);
    check("midrst_data", dout[0], 8'h00);
    check("midrst_perr", perr[0], 1'b0);
    check("midrst_ack_other", ack[1], 1'b0);
    step(4);
    check("midrst_quiet", valid[0], 1'b0);
    send(0, 8'hC3);
    wait_valid(0, 3, "post_rst");
    consume(0, "post_rst");

    // simultaneous accept and new request
    w_a = 8'($urandom_range(0, 255));
    w_b = ~w_a;
    send(0, w_a);
    wait_valid(0, 3, "simul_first");
    send(0, w_b);
    step(2);
    check("simul_pre_data", dout[0], w_a);
    check("simul_pre_perr", perr[0], 1'b0);
    ready[0] = 1'b1;
    step(1);
    ready[0] = 1'b0;
    ack_m[0] = ~ack_m[0];
    check("simul_ack", ack[0], ack_m[0]);
    check("simul_valid_drop", valid[0], 1'b0);
    check("simul_perr", perr[0], 1'b1);
    wait_valid(0, 1, "simul_second");
    consume(0, "simul_second");

    check("final_q0_empty", exp_q0.size(), 0);
    check("final_q1_empty", exp_q1.size(), 0);
    check("final_perr_depth2", perr[1], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_2phase_bundled_receiver.md
# cdc_2phase_bundled_receiver

Receiving end of a 2-phase (toggle) bundled-data clock-domain crossing. Synchronizes an asynchronous request toggle and captures the accompanying data word. Presents the word on a valid/ready interface in the local clock domain. Returns an acknowledge toggle once the word is consumed. Sits beside a sender-side toggle generator; the sender holds data stable and issues no new request toggle until it has seen the ack toggle change.

## Interface
Parameters:
- WORD_WIDTH, 8, width of the bundled data word
- CDC_EXTRA_DEPTH, 0, extra synchronizer stages beyond the base 2

Ports:
- clock  in  1  receiving-domain clock
- clear_n  in  1  reset, synchronous, active-low
- req_toggle_in  in  1  asynchronous request toggle from the sender; every edge is one transfer
- data_in  in  WORD_WIDTH  asynchronous bundled data; stable from before the req edge until the sender sees the ack edge
- ack_toggle_out  out  1  registered ack toggle back to the sender; one edge per consumed word
- valid_out  out  1  held word available
- ready_in  in  1  consumer accepts the word when valid_out and ready_in are both high
- data_out  out  WORD_WIDTH  held word, registered
- protocol_error  out  1  sticky; sender violated the handshake

## Operation
- req_toggle_in passes through a (2 + CDC_EXTRA_DEPTH)-stage bit synchronizer, giving req_sync.
- req_last register holds the req_sync value of the last accepted transfer; new request = (req_sync != req_last).
- States:
  - IDLE: valid_out=0. On a new request, capture data_in into data_out, set req_last=req_sync, and go to HOLD.
  - HOLD: valid_out=1. On valid_out && ready_in, toggle ack_toggle_out and go to IDLE.
- data_in is sampled directly, without a synchronizer. This is safe because data_in is stable for at least the synchronizer depth before req_sync changes.
- Protocol errors:
  - A new request (req_sync != req_last) while in HOLD sets protocol_error.
  - That request is not dropped. After the transition back to IDLE, the mismatch is taken as a fresh transfer.
  - If the sender toggled twice, req_sync returns to req_last and that pair of transfers is lost silently. Only the error flag records it.
- protocol_error clears only on reset.
- No data_out change while in HOLD.

## Timing
- Reset values: valid_out=0, ack_toggle_out=0, data_out=0, protocol_error=0, req_last=0, synchronizer stages=0, state=IDLE.
- Reset mid-HOLD discards the held word and drives ack_toggle_out to 0. The sender must be reset together with this block.
- Latency, req to valid: req_toggle_in changes before edge k. req_sync changes after edge k+1+CDC_EXTRA_DEPTH. valid_out rises and data_out loads after edge k+2+CDC_EXTRA_DEPTH.
- Latency, accept to ack: the accept happens at edge a. valid_out falls and ack_toggle_out toggles after edge a (same edge).
- Back-to-back: the earliest next valid_out is (2+CDC_EXTRA_DEPTH) receiver cycles plus the sender-side ack synchronization after the ack edge. There is no combinational path from ready_in to any output.
- ready_in held high in IDLE has no effect. valid_out stays high indefinitely in HOLD until ready_in.
- Simultaneous accept and new request in the same HOLD cycle:
  - The transfer completes and ack toggles.
  - protocol_error is set, because the sender toggled before it could have seen the ack.
  - The pending request is accepted on the following IDLE cycle.

## Structure
- Shared package: a state enum (IDLE, HOLD) for this block. The base synchronizer depth of 2 is a package constant.
- Sub-module: the existing cdc_bit_synchronizer for req_toggle_in, with EXTRA_DEPTH=CDC_EXTRA_DEPTH. The ack path has no synchronizer here; the sender domain synchronizes it.
- Edge detection is the req_last comparison, not a separate pulse generator, because req_last must advance only on capture.

## Test plan
- Single transfer, CDC_EXTRA_DEPTH=0: data_in=0xA5, toggle req before edge 10, ready_in=1. Expected: valid_out=1 and data_out=0xA5 after edge 12; ack_toggle_out goes 0->1 after edge 13; valid_out=0 after edge 13.
- Backpressure: ready_in=0 for 20 cycles after valid. Expected: valid_out and data_out=0xA5 held, ack unchanged. Raise ready_in: one ack edge, and ack occurs exactly once.
- Four sequential transfers (0x01, 0x02, 0x03, 0x04), with the sender model waiting for the ack edge each time. Expected: four ack edges, data delivered in order, protocol_error=0; repeat with CDC_EXTRA_DEPTH=2 and expect valid_out two cycles later.
- Violation: toggle req again while in HOLD with data_in=0x55. Expected: protocol_error=1 and sticky; after accepting the first word, a second valid_out with 0x55.
- Reset mid-HOLD: clear_n=0 for one edge. Expected: valid_out=0, ack_toggle_out=0, data_out=0, protocol_error=0 on the next cycle; the block accepts a new transfer afterwards.
- Simultaneous: toggle req on the same edge as the accept. Expected: ack toggles, protocol_error=1, and valid_out reasserts with the new word.
